// File: rtl/mul_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: 2-cycle multiply, 33-cycle
// restoring divide, producing {hi, lo} for the HILO pair with a combinational stall.
module mul_div (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        stall,
   output logic        valid,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state;
   logic [31:0] dvd;      // multiplicand / dividend magnitude, becomes the quotient
   logic [31:0] dvs;      // multiplier / divisor magnitude
   logic [31:0] rem;
   logic [4:0]  cnt;
   logic        sgn;
   logic        q_neg;
   logic        r_neg;
   logic        div0;

   logic        is_signed;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [63:0] prod;
   logic [32:0] rem_shift;
   logic        ge;
   logic [31:0] rem_next;
   logic [31:0] q_next;

   assign is_signed = ~op[0];
   assign abs_a     = (is_signed & a[31]) ? 32'd0 - a : a;
   assign abs_b     = (is_signed & b[31]) ? 32'd0 - b : b;

   // Sign-extending to 64 bits lets one multiplier serve both MULT and MULTU.
   assign prod = $signed({{32{sgn & dvd[31]}}, dvd}) * $signed({{32{sgn & dvs[31]}}, dvs});

   assign rem_shift = {rem, dvd[31]};
   assign ge        = rem_shift >= {1'b0, dvs};
   assign rem_next  = ge ? rem_shift[31:0] - dvs : rem_shift[31:0];
   assign q_next    = {dvd[30:0], ge};

   assign stall = ~cancel & ((state == IDLE & start) | state == MUL | state == DIV);

   // NOTE: every register here, datapath included, is assigned with <= so all of them
   // update together from pre-edge values; the datapath is reset too so no X escapes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         valid <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         dvd   <= 32'd0;
         dvs   <= 32'd0;
         rem   <= 32'd0;
         cnt   <= 5'd0;
         sgn   <= 1'b0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         div0  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (cancel) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     sgn   <= is_signed;
                     q_neg <= is_signed & (a[31] ^ b[31]);
                     r_neg <= is_signed & a[31];
                     cnt   <= 5'd0;
                     div0  <= op[1] & (b == 32'd0);
                     if (!op[1]) begin
                        dvd   <= a;
                        dvs   <= b;
                        state <= MUL;
                     end else if (b == 32'd0) begin
                        // Divide by zero: final result is staged now, iterations only count.
                        rem   <= a;
                        dvd   <= 32'hFFFF_FFFF;
                        dvs   <= b;
                        state <= DIV;
                     end else begin
                        rem   <= 32'd0;
                        dvd   <= abs_a;
                        dvs   <= abs_b;
                        state <= DIV;
                     end
                  end
               end
               MUL: begin
                  hi    <= prod[63:32];
                  lo    <= prod[31:0];
                  valid <= 1'b1;
                  state <= DONE;
               end
               DIV: begin
                  cnt <= cnt + 5'd1;
                  if (!div0) begin
                     rem <= rem_next;
                     dvd <= q_next;
                  end
                  if (cnt == 5'd31) begin
                     valid <= 1'b1;
                     state <= DONE;
                     if (div0) begin
                        hi <= rem;
                        lo <= dvd;
                     end else begin
                        hi <= r_neg ? 32'd0 - rem_next : rem_next;
                        lo <= q_neg ? 32'd0 - q_next : q_next;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_div.sv
// Directed self-checking bench for mul_div: multiply/divide results, latency,
// stall/valid handshake, divide by zero, cancel and mid-operation reset.
module tb_mul_div;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        stall;
   logic        valid;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   mul_div dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .stall  (stall),
      .valid  (valid),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one operation at the next falling edge and follows it to DONE,
   // returning positioned in the DONE cycle with start still held high.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
      int lat;
      int pulses;
      int stalls;
      lat    = o[1] ? 33 : 2;
      pulses = 0;
      stalls = 0;
      @(negedge clk);
      start  = 1'b1;
      cancel = 1'b0;
      op     = o;
      a      = x;
      b      = y;
      #1;
      check($sformatf("%s_stall_T", tag), {31'd0, stall}, 32'd1);
      check($sformatf("%s_valid_T", tag), {31'd0, valid}, 32'd0);
      for (int i = 1; i <= lat; i++) begin
         @(negedge clk);
         if (i == 1) begin
            a  = 32'h5A5A_1234;
            b  = 32'h0000_0003;
            op = o ^ 2'b11;
         end
         if (valid) pulses++;
         if (stall) stalls++;
      end
      check($sformatf("%s_valid", tag), {31'd0, valid}, 32'd1);
      check($sformatf("%s_stall_done", tag), {31'd0, stall}, 32'd0);
      check($sformatf("%s_pulses", tag), pulses, 32'd1);
      check($sformatf("%s_stall_cycles", tag), stalls, lat - 1);
      check($sformatf("%s_hi", tag), hi, eh);
      check($sformatf("%s_lo", tag), lo, el);
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      cancel = 1'b0;
      op     = 2'b00;
      a      = 32'd0;
      b      = 32'd0;
      #1;
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Back-to-back issues: each next op is accepted in the IDLE cycle right after DONE.
      run_op("mult_m3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
      run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_m2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      run_op("div_m7_m2",   OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3);
      run_op("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      run_op("mult_min_2",  OP_MULT,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'd0);
      run_op("multu_min_2", OP_MULTU, 32'h8000_0000, 32'd2,         32'd1,         32'd0);
      run_op("div_m5_0",    OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run_op("divu_100_0",  OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);

      // Cancel a DIV at T+10; the killed op must leave hi/lo and valid untouched.
      begin
         int pulses;
         pulses = 0;
         @(negedge clk);
         start = 1'b1;
         op    = OP_DIV;
         a     = 32'd100;
         b     = 32'd7;
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (valid) pulses++;
         end
         cancel = 1'b1;
         #1;
         check("cancel_stall", {31'd0, stall}, 32'd0);
         @(posedge clk);
         #1;
         check("cancel_valid", {31'd0, valid}, 32'd0);
         check("cancel_stall_idle", {31'd0, stall}, 32'd0);
         check("cancel_hi", hi, 32'h0000_0064);
         check("cancel_lo", lo, 32'hFFFF_FFFF);
         check("cancel_pulses", pulses, 32'd0);
      end
      run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

      // Reset at T+5 of a DIV, then a normal operation after release.
      @(negedge clk);
      start = 1'b1;
      op    = OP_DIV;
      a     = 32'd100;
      b     = 32'd7;
      for (int i = 1; i <= 5; i++) @(negedge clk);
      resetn = 1'b0;
      start  = 1'b0;
      #1;
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      check("rst_mid_valid", {31'd0, valid}, 32'd0);
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      run_op("multu_post_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);

      @(negedge clk);
      start = 1'b0;
      #1;
      check("end_valid", {31'd0, valid}, 32'd0);
      check("end_stall", {31'd0, stall}, 32'd0);
      check("end_hi", hi, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
